// File: rtl/baud_tick_gen.sv
// Fractional baud-rate tick generator: oversampling stick plus mid-bit and end-of-bit ticks,
// with a shadowed divisor that only takes effect on a stick, a resync or while disabled.
module baud_tick_gen #(
  parameter int SIZE_BAUD = 24,
  parameter int SIZE_FRAC = 4,
  parameter int OVS       = 16,
  parameter int DIV_RST   = 325,
  parameter int FRAC_RST  = 0
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_en,
  input  logic                   i_resync,
  input  logic                   i_cfg_valid,
  output logic                   o_cfg_ready,
  input  logic [SIZE_BAUD-1:0]   i_div_int,
  input  logic [SIZE_FRAC-1:0]   i_div_frac,
  output logic                   o_stick,
  output logic                   o_btick,
  output logic                   o_mtick,
  output logic [$clog2(OVS)-1:0] o_ovs_cnt
);
  localparam int CNT_W = SIZE_BAUD + 1;
  localparam int OVS_W = $clog2(OVS);
  localparam logic [OVS_W-1:0] OVS_LAST = OVS_W'(OVS - 1);
  localparam logic [OVS_W-1:0] OVS_MID  = OVS_W'(OVS / 2 - 1);

  logic [CNT_W-1:0]     cnt_r;
  logic [CNT_W-1:0]     cnt_nxt_s;
  logic [CNT_W-1:0]     limit_s;
  logic [SIZE_FRAC-1:0] acc_r;
  logic [SIZE_FRAC-1:0] acc_nxt_s;
  logic                 extra_r;
  logic                 extra_nxt_s;
  logic [OVS_W-1:0]     ovs_r;
  logic [OVS_W-1:0]     ovs_nxt_s;
  logic [SIZE_BAUD-1:0] act_int_r;
  logic [SIZE_FRAC-1:0] act_frac_r;
  logic [SIZE_BAUD-1:0] shd_int_r;
  logic [SIZE_FRAC-1:0] shd_frac_r;
  logic                 pending_r;
  logic [SIZE_FRAC:0]   frac_sum_s;
  logic                 stick_s;
  logic                 xfer_s;
  logic                 swap_s;

  // Widened by one bit so act_int + extra never wraps at the top of the divisor range.
  assign limit_s    = {1'b0, act_int_r} + {{SIZE_BAUD{1'b0}}, extra_r};
  assign stick_s    = i_en & ~i_resync & (cnt_r == limit_s);
  assign frac_sum_s = {1'b0, acc_r} + {1'b0, act_frac_r};
  assign xfer_s     = i_cfg_valid & ~pending_r;
  assign swap_s     = pending_r & (stick_s | i_resync | ~i_en);

  assign o_stick     = stick_s;
  assign o_btick     = stick_s & (ovs_r == OVS_LAST);
  assign o_mtick     = stick_s & (ovs_r == OVS_MID);
  assign o_ovs_cnt   = ovs_r;
  assign o_cfg_ready = ~pending_r;

  // Next-state for the period counter, fraction accumulator and bit phase.
  always_comb begin
    cnt_nxt_s   = cnt_r;
    acc_nxt_s   = acc_r;
    extra_nxt_s = extra_r;
    ovs_nxt_s   = ovs_r;
    if (i_resync) begin
      cnt_nxt_s   = {CNT_W{1'b0}};
      acc_nxt_s   = {SIZE_FRAC{1'b0}};
      extra_nxt_s = 1'b0;
      ovs_nxt_s   = {OVS_W{1'b0}};
    end else if (stick_s) begin
      cnt_nxt_s                = {CNT_W{1'b0}};
      {extra_nxt_s, acc_nxt_s} = frac_sum_s;
      if (ovs_r == OVS_LAST) begin
        ovs_nxt_s = {OVS_W{1'b0}};
      end else begin
        ovs_nxt_s = ovs_r + OVS_W'(1);
      end
    end else if (i_en) begin
      cnt_nxt_s = cnt_r + CNT_W'(1);
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // State registers; swap and transfer are exclusive because one needs pending and the other not.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_r      <= {CNT_W{1'b0}};
      acc_r      <= {SIZE_FRAC{1'b0}};
      extra_r    <= 1'b0;
      ovs_r      <= {OVS_W{1'b0}};
      act_int_r  <= SIZE_BAUD'(DIV_RST);
      act_frac_r <= SIZE_FRAC'(FRAC_RST);
      shd_int_r  <= {SIZE_BAUD{1'b0}};
      shd_frac_r <= {SIZE_FRAC{1'b0}};
      pending_r  <= 1'b0;
    end else begin
      cnt_r   <= cnt_nxt_s;
      acc_r   <= acc_nxt_s;
      extra_r <= extra_nxt_s;
      ovs_r   <= ovs_nxt_s;
      if (swap_s) begin
        act_int_r  <= shd_int_r;
        act_frac_r <= shd_frac_r;
        pending_r  <= 1'b0;
      end else if (xfer_s) begin
        shd_int_r  <= i_div_int;
        shd_frac_r <= i_div_frac;
        pending_r  <= 1'b1;
      end else begin
        pending_r <= pending_r;
      end
    end
  end

endmodule

// File: tb/tb_baud_tick_gen.sv
// Directed self-checking bench for baud_tick_gen: period, fraction, handshake, resync,
// enable, asynchronous reset and zero-divisor behaviour with hand-computed tick positions.
module tb_baud_tick_gen;
  logic        i_clk;
  logic        i_rst;
  logic        i_en;
  logic        i_resync;
  logic        i_cfg_valid;
  logic        o_cfg_ready;
  logic [23:0] i_div_int;
  logic [3:0]  i_div_frac;
  logic        o_stick;
  logic        o_btick;
  logic        o_mtick;
  logic [3:0]  o_ovs_cnt;

  int errors = 0;
  int checks = 0;
  int cyc_n  = 0;
  int st_q[$];
  int mt_q[$];
  int bt_q[$];
  int bad;

  baud_tick_gen #(
    .SIZE_BAUD(24), .SIZE_FRAC(4), .OVS(16), .DIV_RST(3), .FRAC_RST(0)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_resync(i_resync),
    .i_cfg_valid(i_cfg_valid), .o_cfg_ready(o_cfg_ready),
    .i_div_int(i_div_int), .i_div_frac(i_div_frac),
    .o_stick(o_stick), .o_btick(o_btick), .o_mtick(o_mtick), .o_ovs_cnt(o_ovs_cnt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Inputs change one time unit after the falling edge; outputs are read a unit later.
  task automatic step();
    @(negedge i_clk);
    #1;
    cyc_n++;
  endtask

  task automatic mark();
    cyc_n = 0;
    st_q.delete();
    mt_q.delete();
    bt_q.delete();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      #1;
      if (o_stick === 1'b1) st_q.push_back(cyc_n);
      if (o_mtick === 1'b1) mt_q.push_back(cyc_n);
      if (o_btick === 1'b1) bt_q.push_back(cyc_n);
      step();
    end
  endtask

  initial begin
    i_rst = 1'b1; i_en = 1'b1; i_resync = 1'b0; i_cfg_valid = 1'b0;
    i_div_int = 24'd0; i_div_frac = 4'd0;
    step(); step();
    #1;
    chk("rst_stick", o_stick, 1'b0);
    chk("rst_btick", o_btick, 1'b0);
    chk("rst_mtick", o_mtick, 1'b0);
    chk("rst_ovs", o_ovs_cnt, 4'd0);
    chk("rst_ready", o_cfg_ready, 1'b1);

    // Basic period, N = 3 from reset
    i_rst = 1'b0;
    mark();
    run(42);
    chk("basic_ovs_c42", o_ovs_cnt, 4'd10);
    run(86);
    chk("basic_nsticks", st_q.size(), 32);
    chk("basic_first", st_q[0], 3);
    chk("basic_last", st_q[31], 127);
    bad = 0;
    for (int i = 1; i < st_q.size(); i++) if (st_q[i] - st_q[i-1] != 4) bad++;
    chk("basic_spacing", bad, 0);
    chk("basic_nmtick", mt_q.size(), 2);
    chk("basic_mtick0", mt_q[0], 31);
    chk("basic_mtick1", mt_q[1], 95);
    chk("basic_nbtick", bt_q.size(), 2);
    chk("basic_btick0", bt_q[0], 63);
    chk("basic_btick1", bt_q[1], 127);

    // Handshake: accept N=5 mid-period, old period completes, second offer ignored
    run(1);
    i_cfg_valid = 1'b1; i_div_int = 24'd5; i_div_frac = 4'd0;
    #1;
    chk("hs_ready_before", o_cfg_ready, 1'b1);
    step();
    i_div_int = 24'd9;
    #1;
    chk("hs_ready_drop", o_cfg_ready, 1'b0);
    mark();
    run(1);
    #1;
    chk("hs_ready_pend", o_cfg_ready, 1'b0);
    chk("hs_old_stick", o_stick, 1'b1);
    run(1);
    i_cfg_valid = 1'b0;
    #1;
    chk("hs_ready_rise", o_cfg_ready, 1'b1);
    run(12);
    chk("hs_nsticks", st_q.size(), 3);
    chk("hs_stick0", st_q[0], 1);
    chk("hs_stick1", st_q[1], 7);
    chk("hs_stick2", st_q[2], 13);

    // Fraction: N=2, F=8 applied through a resync
    i_cfg_valid = 1'b1; i_div_int = 24'd2; i_div_frac = 4'd8;
    step();
    i_cfg_valid = 1'b0;
    #1;
    chk("fr_ready_pend", o_cfg_ready, 1'b0);
    i_resync = 1'b1;
    step();
    i_resync = 1'b0;
    #1;
    chk("fr_ovs_zero", o_ovs_cnt, 4'd0);
    chk("fr_ready", o_cfg_ready, 1'b1);
    mark();
    run(111);
    chk("fr_nsticks", st_q.size(), 32);
    chk("fr_s0", st_q[0], 2);
    chk("fr_s1", st_q[1], 5);
    chk("fr_s2", st_q[2], 9);
    chk("fr_s3", st_q[3], 12);
    chk("fr_s4", st_q[4], 16);
    chk("fr_s31", st_q[31], 110);
    chk("fr_mtick0", mt_q[0], 26);
    chk("fr_mtick1", mt_q[1], 82);
    chk("fr_btick0", bt_q[0], 54);
    chk("fr_btick1", bt_q[1], 110);

    // Resync at cnt == limit with ovs = 9 (N=3 swapped in on a stick)
    i_cfg_valid = 1'b1; i_div_int = 24'd3; i_div_frac = 4'd0;
    step();
    i_cfg_valid = 1'b0;
    run(3);
    mark();
    #1;
    chk("rs_ready_swap", o_cfg_ready, 1'b1);
    run(35);
    #1;
    chk("rs_ovs_before", o_ovs_cnt, 4'd9);
    i_resync = 1'b1;
    #1;
    chk("rs_no_stick", o_stick, 1'b0);
    step();
    i_resync = 1'b0;
    #1;
    chk("rs_ovs_after", o_ovs_cnt, 4'd0);
    mark();
    run(40);
    chk("rs_nmtick", mt_q.size(), 1);
    chk("rs_mtick", mt_q[0], 31);
    chk("rs_stick0", st_q[0], 3);

    // Enable low for 10 cycles while cnt == limit
    run(3);
    i_en = 1'b0;
    #1;
    chk("en_no_stick", o_stick, 1'b0);
    mark();
    run(10);
    chk("en_nsticks_off", st_q.size(), 0);
    chk("en_ovs_frozen", o_ovs_cnt, 4'd10);
    i_en = 1'b1;
    mark();
    run(5);
    chk("en_nsticks_on", st_q.size(), 2);
    chk("en_resume0", st_q[0], 0);
    chk("en_resume1", st_q[1], 4);
    chk("en_ovs_after", o_ovs_cnt, 4'd12);

    // Asynchronous reset with a divisor pending
    i_cfg_valid = 1'b1; i_div_int = 24'd7; i_div_frac = 4'd0;
    step();
    i_cfg_valid = 1'b0;
    #1;
    chk("ar_pending", o_cfg_ready, 1'b0);
    chk("ar_ovs_before", o_ovs_cnt, 4'd12);
    #1;
    i_rst = 1'b1;
    #1;
    chk("ar_stick", o_stick, 1'b0);
    chk("ar_btick", o_btick, 1'b0);
    chk("ar_mtick", o_mtick, 1'b0);
    chk("ar_ovs", o_ovs_cnt, 4'd0);
    chk("ar_ready", o_cfg_ready, 1'b1);
    step();
    i_rst = 1'b0;
    mark();
    run(8);
    chk("ar_nsticks", st_q.size(), 2);
    chk("ar_first", st_q[0], 3);
    chk("ar_ready_after", o_cfg_ready, 1'b1);

    // Zero integer divisor with F=8: idle cycle on each carry
    i_cfg_valid = 1'b1; i_div_int = 24'd0; i_div_frac = 4'd8;
    step();
    i_cfg_valid = 1'b0;
    i_resync = 1'b1;
    step();
    i_resync = 1'b0;
    mark();
    run(8);
    chk("z_nsticks", st_q.size(), 6);
    chk("z_s2", st_q[2], 3);
    chk("z_s5", st_q[5], 7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
